ps2_teclado_rx: RTL and testbench
=================================

Name: ps2_teclado_rx

Overview:
- Upstream stage of the keyboard-command state machine.
- Receives PS/2 keyboard frames (scan code set 2) and validates start, parity and stop bits.
- Filters out break and extended-prefix sequences and translates the six accepted make codes into the 8-bit command codes the downstream FSM compares against.
- Drives the downstream `datotec` input directly. A command code is presented for exactly one clk_i cycle; all other cycles carry the idle code.

Parameters:
- FILTER_LEN, 8: number of consecutive identical synchronized samples required before the filtered ps2c/ps2d level changes.
- TIMEOUT_CYC, 100000: clk_i cycles allowed between successive ps2c falling edges inside a frame before the frame is aborted.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- ps2c_i  in  1  raw PS/2 clock from the connector (asynchronous)
- ps2d_i  in  1  raw PS/2 data from the connector (asynchronous)
- datotec_o  out  8  command code; 8'h00 when idle
- valid_o  out  1  one-cycle strobe, high exactly when datotec_o is non-idle
- err_o  out  1  one-cycle strobe on a parity, start, stop or timeout error

Behaviour:
- Reset: datotec_o=8'h00, valid_o=0, err_o=0, FSM in IDLE, break/ext flags cleared, filtered ps2c/ps2d=1. Reset mid-frame discards the partial frame.
- Input conditioning:
  - 2-FF synchronizer on each line, then a FILTER_LEN stable-sample filter.
  - fall = filtered ps2c was 1 last cycle and is 0 now. Data is sampled only in a cycle where fall=1.
- Frame FSM:
  - IDLE: on fall with data=0 → DATA, bit count=0. On fall with data=1 → stay IDLE and pulse err_o.
  - DATA: on each fall, shift data in LSB-first. After the 8th bit → PARITY.
  - PARITY: on fall, capture the parity bit → STOP.
  - STOP: on fall, check the frame → IDLE.
    - Good frame requires stop=1 and odd parity (XOR of 8 data bits and parity bit = 1).
    - Good frame → set byte_rdy for one cycle. Bad frame → err_o pulse, byte discarded.
  - Timeout: in any non-IDLE state, a counter resets on each fall. Reaching TIMEOUT_CYC → IDLE, err_o pulse, flags unchanged.
- Decode, in the cycle where byte_rdy=1:
  - 0xF0: set brk flag, no output.
  - 0xE0: set ext flag, no output.
  - Any other byte with brk=1: clear brk and ext, no output (key release).
  - Otherwise clear ext and map the byte (registered):
    - 0x43 (I) → 8'b10000000
    - 0x32 (B) → 8'b11000001
    - 0x1C (A) → 8'b10001000
    - 0x21 (C) → 8'b11000110
    - 0x23 (D) → 8'b10100001
    - 0x5A (Enter, incl. keypad E0 5A) → 8'b11111110
    - Unmapped byte → no output.
- Latency: STOP-bit fall detected in cycle N → datotec_o/valid_o asserted in cycle N+1 only, back to 8'h00 in N+2.
- Typematic repeats (repeated make codes without a break) each produce a fresh one-cycle output.
- err_o and valid_o are never high in the same cycle.

Decomposition:
- Package ps2_teclado_pkg holds:
  - scan-code constants (SC_I, SC_B, SC_A, SC_C, SC_D, SC_ENTER, SC_BREAK, SC_EXT);
  - command-code constants (CMD_INICIO, CMD_IGN, CMD_PRES, CMD_TEMP_ALTA, CMD_TEMP_BAJA, CMD_ENTER, CMD_IDLE);
  - FSM state encodings.
- Sub-module ps2_filtro_flanco: synchronizer, glitch filter and falling-edge detect, one instance per line (edge output used on the clock instance only).

Test Plan:
- Send a valid frame 0x43 (parity 0) → valid_o=1 and datotec_o=8'b10000000 for exactly one cycle, one cycle after the stop-bit fall; 8'h00 before and after.
- Send 0x5A, then F0, then 5A → exactly one 8'b11111110 pulse (from the first frame); the F0 5A pair produces nothing.
- Send E0 5A → one 8'b11111110 pulse. Send E0 F0 5A → no output, and both flags are clear afterwards.
- Send 0x1C with the parity bit inverted → err_o pulses once, valid_o stays 0. A following correct 0x1C → 8'b10001000.
- Send 5 bits of a frame, then hold ps2c high for TIMEOUT_CYC cycles → err_o pulse and return to IDLE. A following frame 0x32 → 8'b11000001.
- Add 2-cycle glitches on ps2c (shorter than FILTER_LEN) → no extra bits shifted and decoding unaffected. Assert rst_i mid-frame → all outputs 0 and the next full frame decodes correctly.

Source files
------------

// File: rtl/ps2_teclado_pkg.sv
// ps2_teclado_pkg
// Shared constants for the PS/2 keyboard receiver:
//   - scan-code set 2 values of the keys the command FSM cares about
//   - 8-bit command codes driven onto datotec
//   - frame FSM state encodings and the scan-code -> command map
package ps2_teclado_pkg;

  // Scan codes (set 2)
  localparam logic [7:0] SC_I     = 8'h43;
  localparam logic [7:0] SC_B     = 8'h32;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_C     = 8'h21;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Command codes understood by the downstream FSM
  localparam logic [7:0] CMD_INICIO    = 8'b1000_0000;
  localparam logic [7:0] CMD_IGN       = 8'b1100_0001;
  localparam logic [7:0] CMD_PRES      = 8'b1000_1000;
  localparam logic [7:0] CMD_TEMP_ALTA = 8'b1100_0110;
  localparam logic [7:0] CMD_TEMP_BAJA = 8'b1010_0001;
  localparam logic [7:0] CMD_ENTER     = 8'b1111_1110;
  localparam logic [7:0] CMD_IDLE      = 8'h00;

  // Frame FSM state encodings
  typedef logic [1:0] estado_t;
  localparam estado_t ST_IDLE   = 2'd0;
  localparam estado_t ST_DATA   = 2'd1;
  localparam estado_t ST_PARITY = 2'd2;
  localparam estado_t ST_STOP   = 2'd3;

  // Make code -> command; CMD_IDLE means "not a command key".
  function automatic logic [7:0] map_scan(input logic [7:0] sc);
    logic [7:0] cmd;
    case (sc)
      SC_I:     cmd = CMD_INICIO;
      SC_B:     cmd = CMD_IGN;
      SC_A:     cmd = CMD_PRES;
      SC_C:     cmd = CMD_TEMP_ALTA;
      SC_D:     cmd = CMD_TEMP_BAJA;
      SC_ENTER: cmd = CMD_ENTER;
      default:  cmd = CMD_IDLE;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/ps2_teclado_rx_if.sv
// ps2_teclado_rx_if
// Bundle between the PS/2 connector side, the receiver and the command FSM.
//   ps2c_i / ps2d_i : raw PS/2 clock and data (asynchronous to clk_i)
//   datotec_o       : command code, CMD_IDLE (8'h00) when nothing to report
//   valid_o         : one-cycle strobe, high exactly when datotec_o != 8'h00
//   err_o           : one-cycle strobe on start/parity/stop/timeout error
//   dbg_state, dbg_brk, dbg_ext : frame FSM state and decode flags
//
// Handshake: valid_o is a pure strobe with no ready/backpressure. The
// consumer must take datotec_o in the single cycle valid_o is high; the
// PS/2 keyboard cannot be stalled, so there is nothing to hold it against.
interface ps2_teclado_rx_if;
  import ps2_teclado_pkg::*;

  logic       ps2c_i;
  logic       ps2d_i;
  logic [7:0] datotec_o;
  logic       valid_o;
  logic       err_o;
  estado_t    dbg_state;
  logic       dbg_brk;
  logic       dbg_ext;

  // master: keyboard/connector side plus the command consumer
  modport master (
    output ps2c_i, ps2d_i,
    input  datotec_o, valid_o, err_o, dbg_state, dbg_brk, dbg_ext
  );

  // slave: the receiver itself
  modport slave (
    input  ps2c_i, ps2d_i,
    output datotec_o, valid_o, err_o, dbg_state, dbg_brk, dbg_ext
  );
endinterface

// File: rtl/ps2_filtro_flanco.sv
// ps2_filtro_flanco
// Conditions one raw PS/2 line: 2-FF synchronizer, then a stable-sample
// filter that only changes the output level after FILTER_LEN consecutive
// synchronized samples disagree with it, then a falling-edge detector.
//   clk_i, rst_i : system clock, async active-high reset
//   raw          : asynchronous input line
//   level        : filtered level (1 in reset, the PS/2 idle level)
//   fall         : high for the one cycle in which level has just gone 1->0
module ps2_filtro_flanco #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw,
  output logic level,
  output logic fall
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          sync1;
  logic          sync2;
  logic          lvl_q;
  logic          lvl_d1;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      lvl_q  <= 1'b1;
      lvl_d1 <= 1'b1;
      cnt    <= '0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      lvl_d1 <= lvl_q;
      // cnt holds how many disagreeing samples have been seen in a row;
      // the FILTER_LEN-th one flips the level.
      if (sync2 == lvl_q) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        lvl_q <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = lvl_q;
  assign fall  = lvl_d1 & ~lvl_q;

endmodule

// File: rtl/ps2_teclado_rx.sv
// ps2_teclado_rx
// PS/2 keyboard receiver feeding the keyboard-command FSM. Frames are
// checked for start/parity/stop, break (F0) and extended (E0) prefixes are
// filtered out, and the six accepted make codes become one-cycle command
// codes on datotec_o.
//   clk_i : system clock
//   rst_i : asynchronous active-high reset; discards any partial frame
//   bus   : ps2_teclado_rx_if.slave (raw PS/2 lines in; datotec_o,
//           valid_o, err_o and FSM debug state out)
// Parameters:
//   FILTER_LEN  : stable samples needed before a filtered line changes
//   TIMEOUT_CYC : max clk_i cycles between ps2c falls inside a frame
module ps2_teclado_rx
  import ps2_teclado_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input logic              clk_i,
  input logic              rst_i,
  ps2_teclado_rx_if.slave  bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic          c_fall;
  logic          d_level;
  logic          unused_c_level;
  logic          unused_d_fall;

  estado_t       state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_q;
  logic [TW-1:0] to_cnt;
  logic          brk;
  logic          ext;
  logic [7:0]    datotec_q;
  logic          valid_q;
  logic          err_q;

  logic          frame_good;
  logic          byte_rdy;
  logic          to_hit;
  logic [7:0]    cmd;

  ps2_filtro_flanco #(.FILTER_LEN(FILTER_LEN)) u_filtro_c (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .raw   (bus.ps2c_i),
    .level (unused_c_level),
    .fall  (c_fall)
  );

  ps2_filtro_flanco #(.FILTER_LEN(FILTER_LEN)) u_filtro_d (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .raw   (bus.ps2d_i),
    .level (d_level),
    .fall  (unused_d_fall)
  );

  // byte_rdy is combinational so the registered command lands in the
  // cycle right after the stop-bit fall. The timeout only fires in a cycle
  // without a fall, which keeps it exclusive with byte_rdy.
  always_comb begin
    frame_good = d_level & (^{shreg, par_q});
    byte_rdy   = (state == ST_STOP) & c_fall & frame_good;
    to_hit     = (state != ST_IDLE) & ~c_fall & (to_cnt == TW'(TIMEOUT_CYC - 1));
    cmd        = map_scan(shreg);
  end

  // Frame FSM
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_q   <= 1'b0;
      to_cnt  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;

      if ((state == ST_IDLE) || c_fall) to_cnt <= '0;
      else                              to_cnt <= to_cnt + 1'b1;

      case (state)
        ST_IDLE: begin
          if (c_fall) begin
            if (!d_level) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (c_fall) begin
            shreg   <= {d_level, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (c_fall) begin
            par_q <= d_level;
            state <= ST_STOP;
          end
        end
        default: begin
          if (c_fall) begin
            state <= ST_IDLE;
            if (!frame_good) err_q <= 1'b1;
          end
        end
      endcase

      if (to_hit) begin
        state <= ST_IDLE;
        err_q <= 1'b1;
      end
    end
  end

  // Decode: prefixes only set flags; a byte following F0 is a release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      brk       <= 1'b0;
      ext       <= 1'b0;
      datotec_q <= CMD_IDLE;
      valid_q   <= 1'b0;
    end else begin
      datotec_q <= CMD_IDLE;
      valid_q   <= 1'b0;
      if (byte_rdy) begin
        if (shreg == SC_BREAK) begin
          brk <= 1'b1;
        end else if (shreg == SC_EXT) begin
          ext <= 1'b1;
        end else if (brk) begin
          brk <= 1'b0;
          ext <= 1'b0;
        end else begin
          ext       <= 1'b0;
          datotec_q <= cmd;
          valid_q   <= (cmd != CMD_IDLE);
        end
      end
    end
  end

  assign bus.datotec_o = datotec_q;
  assign bus.valid_o   = valid_q;
  assign bus.err_o     = err_q;
  assign bus.dbg_state = state;
  assign bus.dbg_brk   = brk;
  assign bus.dbg_ext   = ext;

endmodule

// File: tb/tb_ps2_teclado_rx.sv
// tb_ps2_teclado_rx
// Directed bench for ps2_teclado_rx: drives PS/2 frames bit by bit and
// checks decoded commands, error strobes, flags and output timing.
module tb_ps2_teclado_rx;
  import ps2_teclado_pkg::*;

  localparam int unsigned FILTER_LEN  = 8;
  localparam int unsigned TIMEOUT_CYC = 300;
  // raw stop-bit drop -> output: 2 sync + FILTER_LEN filter + 1 output reg
  localparam int LATENCY = FILTER_LEN + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  ps2_teclado_rx_if bus();

  ps2_teclado_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // ---------------- scoreboard / monitor ----------------
  int         checks = 0;
  int         passed = 0;
  int         vcnt = 0;
  int         ecnt = 0;
  int         mon_bad = 0;
  int         last_vcyc = 0;
  int         stop_cyc = 0;
  logic [7:0] last_cmd = 8'h00;
  logic       prev_valid = 1'b0;
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (bus.valid_o) begin
      vcnt++;
      last_cmd  = bus.datotec_o;
      last_vcyc = cyc;
      if (prev_valid) mon_bad++;
      if (exp_q.size() == 0) mon_bad++;
      else if (exp_q.pop_front() !== bus.datotec_o) mon_bad++;
    end
    if (bus.err_o) ecnt++;
    if (bus.valid_o && bus.err_o) mon_bad++;
    if ((bus.datotec_o != 8'h00) != bus.valid_o) mon_bad++;
    prev_valid = bus.valid_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  // One PS/2 bit: data set mid-high, clock low 20 cycles, high 20 cycles.
  // With glitch=1 a 2-cycle low spike is injected during the high phase.
  task automatic send_bit(input logic b, input bit glitch, input bit is_stop);
    bus.ps2d_i = b;
    repeat (10) @(negedge clk);
    if (is_stop) stop_cyc = cyc;
    bus.ps2c_i = 1'b0;
    repeat (20) @(negedge clk);
    bus.ps2c_i = 1'b1;
    if (glitch) begin
      repeat (4) @(negedge clk);
      bus.ps2c_i = 1'b0;
      repeat (2) @(negedge clk);
      bus.ps2c_i = 1'b1;
      repeat (4) @(negedge clk);
    end else begin
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input bit bad_stop, input bit glitch);
    logic par;
    par = bad_par ? (^b) : ~(^b);
    send_bit(1'b0, glitch, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch, 1'b0);
    send_bit(par, glitch, 1'b0);
    send_bit(~bad_stop, glitch, 1'b1);
    bus.ps2d_i = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(b[i], 1'b0, 1'b0);
    bus.ps2d_i = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  int v0, e0;

  initial begin
    bus.ps2c_i = 1'b1;
    bus.ps2d_i = 1'b1;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_datotec", bus.datotec_o, 8'h00);
    chk("rst_valid",   bus.valid_o,   1'b0);
    chk("rst_err",     bus.err_o,     1'b0);
    chk("rst_state",   bus.dbg_state, ST_IDLE);
    chk("rst_flags",   {bus.dbg_brk, bus.dbg_ext}, 2'b00);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 0x43 -> INICIO, exact latency and single pulse
    v0 = vcnt; e0 = ecnt;
    exp_q.push_back(8'b1000_0000);
    send_frame(8'h43, 1'b0, 1'b0, 1'b0);
    chk("i_count",   vcnt - v0, 1);
    chk("i_cmd",     last_cmd, 8'b1000_0000);
    chk("i_latency", last_vcyc - stop_cyc, LATENCY);
    chk("i_err",     ecnt - e0, 0);

    // 5A, F0, 5A -> only the first Enter
    v0 = vcnt;
    exp_q.push_back(8'b1111_1110);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    chk("enter_cmd", last_cmd, 8'b1111_1110);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    chk("brk_set", bus.dbg_brk, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    chk("enter_rel_count", vcnt - v0, 1);
    chk("brk_clr", bus.dbg_brk, 1'b0);

    // E0 5A -> keypad Enter
    v0 = vcnt;
    exp_q.push_back(8'b1111_1110);
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    chk("ext_set", bus.dbg_ext, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    chk("kp_enter_count", vcnt - v0, 1);
    chk("ext_clr_make", bus.dbg_ext, 1'b0);

    // E0 F0 5A -> release, nothing out, both flags clear
    v0 = vcnt;
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    chk("ext_brk_flags", {bus.dbg_brk, bus.dbg_ext}, 2'b11);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    chk("kp_rel_count", vcnt - v0, 0);
    chk("kp_rel_flags", {bus.dbg_brk, bus.dbg_ext}, 2'b00);

    // 0x1C bad parity -> err, then good 0x1C -> PRES
    v0 = vcnt; e0 = ecnt;
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    chk("par_err", ecnt - e0, 1);
    chk("par_noval", vcnt - v0, 0);
    exp_q.push_back(8'b1000_1000);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    chk("a_cmd", last_cmd, 8'b1000_1000);
    chk("a_count", vcnt - v0, 1);

    // typematic repeat -> fresh pulse
    v0 = vcnt;
    exp_q.push_back(8'b1000_1000);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    chk("repeat_count", vcnt - v0, 1);

    // bad stop bit -> err
    v0 = vcnt; e0 = ecnt;
    send_frame(8'h21, 1'b0, 1'b1, 1'b0);
    chk("stop_err", ecnt - e0, 1);
    chk("stop_noval", vcnt - v0, 0);

    // start bit of 1 -> err, stay idle
    e0 = ecnt;
    send_bit(1'b1, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    chk("start_err", ecnt - e0, 1);
    chk("start_state", bus.dbg_state, ST_IDLE);

    // unmapped make code -> nothing
    v0 = vcnt; e0 = ecnt;
    send_frame(8'h15, 1'b0, 1'b0, 1'b0);
    chk("unmapped", vcnt - v0, 0);
    chk("unmapped_err", ecnt - e0, 0);

    // timeout after 5 bits, then 0x32 -> IGN
    v0 = vcnt; e0 = ecnt;
    send_partial(8'h32, 4);
    chk("to_mid_state", bus.dbg_state, ST_DATA);
    repeat (TIMEOUT_CYC + 50) @(negedge clk);
    chk("to_err", ecnt - e0, 1);
    chk("to_state", bus.dbg_state, ST_IDLE);
    exp_q.push_back(8'b1100_0001);
    send_frame(8'h32, 1'b0, 1'b0, 1'b0);
    chk("b_cmd", last_cmd, 8'b1100_0001);
    chk("b_count", vcnt - v0, 1);

    // glitches on ps2c shorter than FILTER_LEN
    v0 = vcnt; e0 = ecnt;
    exp_q.push_back(8'b1100_0110);
    send_frame(8'h21, 1'b0, 1'b0, 1'b1);
    chk("glitch_c_cmd", last_cmd, 8'b1100_0110);
    exp_q.push_back(8'b1010_0001);
    send_frame(8'h23, 1'b0, 1'b0, 1'b1);
    chk("glitch_d_cmd", last_cmd, 8'b1010_0001);
    chk("glitch_count", vcnt - v0, 2);
    chk("glitch_err", ecnt - e0, 0);

    // reset mid-frame with brk set, then a full frame
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    send_partial(8'h43, 4);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("mrst_out", {bus.datotec_o, bus.valid_o, bus.err_o}, 10'h000);
    chk("mrst_state", bus.dbg_state, ST_IDLE);
    chk("mrst_flags", {bus.dbg_brk, bus.dbg_ext}, 2'b00);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    v0 = vcnt;
    exp_q.push_back(8'b1010_0001);
    send_frame(8'h23, 1'b0, 1'b0, 1'b0);
    chk("post_rst_cmd", last_cmd, 8'b1010_0001);
    chk("post_rst_count", vcnt - v0, 1);

    repeat (20) @(negedge clk);
    chk("monitor_violations", mon_bad, 0);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
